// File: rtl/button_debounce_pkg.sv
// button_debounce_pkg
//   Purpose: constants and helpers shared by the button debouncer and its
//   per-channel sub-module. Defaults come from the board-wide button_pkg.vh,
//   so the debouncer and the Wishbone button register agree on polarity and
//   channel count.
//   Ports: none (package).
`include "button_pkg.vh"

package button_debounce_pkg;

  localparam logic BTN_PRESSED_LVL     = `BTN_PRESSED;
  localparam logic BTN_RELEASED_LVL    = `BTN_RELEASED;
  localparam int   DEF_NUM_BUTTONS     = `BTN_NUM_BUTTONS;
  localparam int   DEF_DEBOUNCE_CYCLES = `BTN_DEBOUNCE_CYCLES;
  localparam int   DEF_CNT_W           = `BTN_CNT_W;

  // Which pulse an accepted level change produces.
  typedef struct packed {
    logic press;
    logic rel;
  } btn_edge_t;

  // Classify the newly accepted debounced level as a press or a release.
  function automatic btn_edge_t classify_edge(input logic new_level);
    btn_edge_t edge_s;
    edge_s.press = (new_level == BTN_PRESSED_LVL);
    edge_s.rel   = (new_level == BTN_RELEASED_LVL);
    return edge_s;
  endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// button_debounce_ch
//   Purpose: one debounce channel. A 2-FF synchronizer feeds a saturating
//   counter; the debounced level only follows the synchronized pin after it
//   has disagreed with the current level for DEBOUNCE_CYCLES consecutive
//   clocks. A single agreeing clock restarts the count.
//   Ports:
//     I_clk      in   1  system clock
//     I_reset    in   1  synchronous active-high reset
//     I_raw      in   1  raw asynchronous pin level, 0 = pressed
//     O_level    out  1  debounced level, 0 = pressed (registered)
//     O_press    out  1  one-cycle pulse on an accepted 1->0 change (registered)
//     O_release  out  1  one-cycle pulse on an accepted 0->1 change (registered)
module button_debounce_ch
  import button_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic I_clk,
  input  logic I_reset,
  input  logic I_raw,
  output logic O_level,
  output logic O_press,
  output logic O_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'sd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'sd1);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             press_r;
  logic             release_r;
  logic [CNT_W-1:0] cnt_r;

  logic [CNT_W-1:0] cnt_nxt_s;
  logic             level_nxt_s;
  logic             press_nxt_s;
  logic             release_nxt_s;
  btn_edge_t        edge_s;

  // Debounce decision: clear, accept, or keep counting the mismatch run.
  always_comb begin
    cnt_nxt_s     = {CNT_W{1'b0}};
    level_nxt_s   = level_r;
    press_nxt_s   = 1'b0;
    release_nxt_s = 1'b0;
    edge_s        = classify_edge(sync2_r);
    if (sync2_r == level_r) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      // Counter stops at CNT_LAST, so it can never wrap.
      level_nxt_s   = sync2_r;
      press_nxt_s   = edge_s.press;
      release_nxt_s = edge_s.rel;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // Synchronizer, counter, level and pulse registers.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      sync1_r   <= BTN_RELEASED_LVL;
      sync2_r   <= BTN_RELEASED_LVL;
      cnt_r     <= {CNT_W{1'b0}};
      level_r   <= BTN_RELEASED_LVL;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      sync1_r   <= I_raw;
      sync2_r   <= sync1_r;
      cnt_r     <= cnt_nxt_s;
      level_r   <= level_nxt_s;
      press_r   <= press_nxt_s;
      release_r <= release_nxt_s;
    end
  end

  assign O_level   = level_r;
  assign O_press   = press_r;
  assign O_release = release_r;

endmodule

// File: rtl/button_pkg.vh
// Shared button constants, also included by the Wishbone button register.
// Pin polarity is active-low: a pressed button reads 0.
`ifndef BUTTON_PKG_VH
`define BUTTON_PKG_VH

`define BTN_PRESSED         1'b0
`define BTN_RELEASED        1'b1
`define BTN_NUM_BUTTONS     5
`define BTN_DEBOUNCE_CYCLES 250000
`define BTN_CNT_W           18

`endif

// File: rtl/button_debounce.sv
// button_debounce
//   Purpose: conditions NUM_BUTTONS raw active-low push-button pins for the
//   Wishbone button register. Each channel is synchronized and debounced
//   independently; the debounced bus keeps pin polarity (0 = pressed).
//   Optional feature: define BUTTON_DEBOUNCE_IRQ_EN to build sticky press
//   flags (O_pending, write-1-to-clear via I_irq_clear, set wins over clear)
//   and O_irq = |pending. Without it O_pending/O_irq are tied to 0 and
//   I_irq_clear is ignored; the port list is the same either way.
//   Ports:
//     I_clk         in   1            system clock
//     I_reset       in   1            synchronous active-high reset
//     I_button_raw  in   NUM_BUTTONS  raw pin levels, async, 0 = pressed
//     O_button      out  NUM_BUTTONS  debounced levels, 0 = pressed
//     O_press       out  NUM_BUTTONS  one-cycle pulse per accepted press
//     O_release     out  NUM_BUTTONS  one-cycle pulse per accepted release
//     I_irq_clear   in   NUM_BUTTONS  write-1-to-clear pending bits
//     O_pending     out  NUM_BUTTONS  sticky press flags
//     O_irq         out  1            any pending flag set
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int NUM_BUTTONS     = DEF_NUM_BUTTONS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                   I_clk,
  input  logic                   I_reset,
  input  logic [NUM_BUTTONS-1:0] I_button_raw,
  output logic [NUM_BUTTONS-1:0] O_button,
  output logic [NUM_BUTTONS-1:0] O_press,
  output logic [NUM_BUTTONS-1:0] O_release,
  input  logic [NUM_BUTTONS-1:0] I_irq_clear,
  output logic [NUM_BUTTONS-1:0] O_pending,
  output logic                   O_irq
);

  logic [NUM_BUTTONS-1:0] press_s;

  generate
    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_ch
      button_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_ch (
        .I_clk     (I_clk),
        .I_reset   (I_reset),
        .I_raw     (I_button_raw[gi]),
        .O_level   (O_button[gi]),
        .O_press   (press_s[gi]),
        .O_release (O_release[gi])
      );
    end
  endgenerate

  assign O_press = press_s;

`ifdef BUTTON_DEBOUNCE_IRQ_EN
  logic [NUM_BUTTONS-1:0] pending_r;
  logic [NUM_BUTTONS-1:0] pending_nxt_s;
  logic                   irq_r;

  // Sticky flags: OR-ing the press in after the clear makes a set win.
  always_comb begin
    pending_nxt_s = (pending_r & ~I_irq_clear) | press_s;
  end

  // Pending and irq registers; irq tracks the new pending value.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      pending_r <= {NUM_BUTTONS{1'b0}};
      irq_r     <= 1'b0;
    end else begin
      pending_r <= pending_nxt_s;
      irq_r     <= |pending_nxt_s;
    end
  end

  assign O_pending = pending_r;
  assign O_irq     = irq_r;
`else
  logic unused_irq_clear_s;

  assign unused_irq_clear_s = ^I_irq_clear;
  assign O_pending          = {NUM_BUTTONS{1'b0}};
  assign O_irq              = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce
//   Bench for button_debounce with NUM_BUTTONS=5, DEBOUNCE_CYCLES=8.
//   Each scenario pushes one expected record per clock edge (levels and
//   pulses) into a scoreboard queue while it drives stimulus, then pops and
//   compares one record per edge, sampling 1 time unit after the edge.
//   Pending/irq expectations come from a small sticky-flag model.
module tb_button_debounce;

  localparam int NB = 5;
  localparam int DC = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] raw;
  logic [NB-1:0] clr;
  logic [NB-1:0] O_button;
  logic [NB-1:0] O_press;
  logic [NB-1:0] O_release;
  logic [NB-1:0] O_pending;
  logic          O_irq;

  always #5 clk = ~clk;

  button_debounce #(
    .NUM_BUTTONS     (NB),
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (18)
  ) dut (
    .I_clk        (clk),
    .I_reset      (rst),
    .I_button_raw (raw),
    .O_button     (O_button),
    .O_press      (O_press),
    .O_release    (O_release),
    .I_irq_clear  (clr),
    .O_pending    (O_pending),
    .O_irq        (O_irq)
  );

  typedef struct {
    int            e;
    logic [NB-1:0] btn;
    logic [NB-1:0] prs;
    logic [NB-1:0] rel;
  } exp_t;

  exp_t          sb[$];
  exp_t          ex;
  int            e = 0;
  int            checks = 0;
  int            errors = 0;
  logic [NB-1:0] m_pend = 5'b00000;
  logic [NB-1:0] m_press_prev = 5'b00000;

  function automatic void push(input int at, input logic [NB-1:0] btn,
                               input logic [NB-1:0] prs, input logic [NB-1:0] rel);
    exp_t r;
    r.e = at; r.btn = btn; r.prs = prs; r.rel = rel;
    sb.push_back(r);
  endfunction

  // Advance one edge and update the sticky-flag model for that edge.
  task automatic tick();
    logic [NB-1:0] clr_q;
    logic          rst_q;
    clr_q = clr;
    rst_q = rst;
    @(posedge clk);
    e++;
    #1;
`ifdef BUTTON_DEBOUNCE_IRQ_EN
    if (rst_q) m_pend = 5'b00000;
    else       m_pend = (m_pend & ~clr_q) | m_press_prev;
`else
    m_pend = 5'b00000;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; raw = 5'b11111; clr = 5'b00000;
    for (int k = 1; k <= 2; k++) push(e + k, 5'b11111, 5'b00000, 5'b00000);
    for (int k = 1; k <= 2; k++) begin
      tick();
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL reset_sb edge=%0d got empty queue, need an entry", e);
      end else begin
        ex = sb.pop_front();
        if (ex.e !== e || {O_button, O_press, O_release} !== {ex.btn, ex.prs, ex.rel}) begin
          errors++;
          $display("FAIL reset edge=%0d got btn=%b prs=%b rel=%b, need btn=%b prs=%b rel=%b (entry %0d)",
                   e, O_button, O_press, O_release, ex.btn, ex.prs, ex.rel, ex.e);
        end
        m_press_prev = ex.prs;
      end
      checks++;
      if ({O_pending, O_irq} !== {m_pend, |m_pend}) begin
        errors++; $display("FAIL reset_irq edge=%0d got pend=%b irq=%b, need pend=%b irq=%b",
                           e, O_pending, O_irq, m_pend, |m_pend);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_press();
    raw = 5'b11110;
    for (int k = 1; k <= 12; k++)
      push(e + k, (k >= 10) ? 5'b11110 : 5'b11111, (k == 10) ? 5'b00001 : 5'b00000, 5'b00000);
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL press_sb edge=%0d got empty queue, need an entry", e);
      end else begin
        ex = sb.pop_front();
        if (ex.e !== e || {O_button, O_press, O_release} !== {ex.btn, ex.prs, ex.rel}) begin
          errors++;
          $display("FAIL press edge=%0d got btn=%b prs=%b rel=%b, need btn=%b prs=%b rel=%b (entry %0d)",
                   e, O_button, O_press, O_release, ex.btn, ex.prs, ex.rel, ex.e);
        end
        m_press_prev = ex.prs;
      end
      checks++;
      if ({O_pending, O_irq} !== {m_pend, |m_pend}) begin
        errors++; $display("FAIL press_irq edge=%0d got pend=%b irq=%b, need pend=%b irq=%b",
                           e, O_pending, O_irq, m_pend, |m_pend);
      end
    end
  endtask

  task automatic test_bounce();
    // 40 clocks of toggling every 3 clocks, then settle low.
    for (int k = 0; k < 52; k++) begin
      if (k < 40) begin
        raw[1] = ((k / 3) % 2 == 0) ? 1'b0 : 1'b1;
        push(e + 1, 5'b11110, 5'b00000, 5'b00000);
      end else begin
        if (k == 40) raw[1] = 1'b0;
        push(e + 1, (k >= 49) ? 5'b11100 : 5'b11110, (k == 49) ? 5'b00010 : 5'b00000, 5'b00000);
      end
      tick();
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL bounce_sb edge=%0d got empty queue, need an entry", e);
      end else begin
        ex = sb.pop_front();
        if (ex.e !== e || {O_button, O_press, O_release} !== {ex.btn, ex.prs, ex.rel}) begin
          errors++;
          $display("FAIL bounce k=%0d edge=%0d got btn=%b prs=%b rel=%b, need btn=%b prs=%b rel=%b",
                   k, e, O_button, O_press, O_release, ex.btn, ex.prs, ex.rel);
        end
        m_press_prev = ex.prs;
      end
      checks++;
      if ({O_pending, O_irq} !== {m_pend, |m_pend}) begin
        errors++; $display("FAIL bounce_irq edge=%0d got pend=%b irq=%b, need pend=%b irq=%b",
                           e, O_pending, O_irq, m_pend, |m_pend);
      end
    end
  endtask

  task automatic test_release_simul();
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 0) begin
        raw = 5'b00000;
        for (int k = 1; k <= 12; k++)
          push(e + k, (k >= 10) ? 5'b00000 : 5'b11100, (k == 10) ? 5'b11100 : 5'b00000, 5'b00000);
      end else begin
        raw = 5'b11111;
        for (int k = 1; k <= 12; k++)
          push(e + k, (k >= 10) ? 5'b11111 : 5'b00000, 5'b00000, (k == 10) ? 5'b11111 : 5'b00000);
      end
      for (int k = 1; k <= 12; k++) begin
        tick();
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL simul_sb edge=%0d got empty queue, need an entry", e);
        end else begin
          ex = sb.pop_front();
          if (ex.e !== e || {O_button, O_press, O_release} !== {ex.btn, ex.prs, ex.rel}) begin
            errors++;
            $display("FAIL simul ph=%0d edge=%0d got btn=%b prs=%b rel=%b, need btn=%b prs=%b rel=%b",
                     phase, e, O_button, O_press, O_release, ex.btn, ex.prs, ex.rel);
          end
          m_press_prev = ex.prs;
        end
        checks++;
        if ({O_pending, O_irq} !== {m_pend, |m_pend}) begin
          errors++; $display("FAIL simul_irq edge=%0d got pend=%b irq=%b, need pend=%b irq=%b",
                             e, O_pending, O_irq, m_pend, |m_pend);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    raw = 5'b11011;
    for (int k = 1; k <= 19; k++)
      push(e + k, (k >= 17) ? 5'b11011 : 5'b11111, (k == 17) ? 5'b00100 : 5'b00000, 5'b00000);
    for (int k = 1; k <= 19; k++) begin
      tick();
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL rstmid_sb edge=%0d got empty queue, need an entry", e);
      end else begin
        ex = sb.pop_front();
        if (ex.e !== e || {O_button, O_press, O_release} !== {ex.btn, ex.prs, ex.rel}) begin
          errors++;
          $display("FAIL rstmid k=%0d edge=%0d got btn=%b prs=%b rel=%b, need btn=%b prs=%b rel=%b",
                   k, e, O_button, O_press, O_release, ex.btn, ex.prs, ex.rel);
        end
        m_press_prev = ex.prs;
      end
      checks++;
      if ({O_pending, O_irq} !== {m_pend, |m_pend}) begin
        errors++; $display("FAIL rstmid_irq edge=%0d got pend=%b irq=%b, need pend=%b irq=%b",
                           e, O_pending, O_irq, m_pend, |m_pend);
      end
      if (k == 6) rst = 1'b1;
      if (k == 7) rst = 1'b0;
    end
  endtask

  task automatic test_irq();
    // Phases: 0 reset, 1 press ch3, 2 release ch3, 3 press with clear, 4 clear alone.
    for (int phase = 0; phase < 5; phase++) begin
      int n;
      case (phase)
        0: begin
          rst = 1'b1; raw = 5'b11111; n = 1;
          push(e + 1, 5'b11111, 5'b00000, 5'b00000);
        end
        1, 3: begin
          raw = 5'b10111; n = 12;
          for (int k = 1; k <= 12; k++)
            push(e + k, (k >= 10) ? 5'b10111 : 5'b11111, (k == 10) ? 5'b01000 : 5'b00000, 5'b00000);
        end
        2: begin
          raw = 5'b11111; n = 12;
          for (int k = 1; k <= 12; k++)
            push(e + k, (k >= 10) ? 5'b11111 : 5'b10111, 5'b00000, (k == 10) ? 5'b01000 : 5'b00000);
        end
        default: begin
          clr = 5'b01000; n = 3;
          for (int k = 1; k <= 3; k++) push(e + k, 5'b10111, 5'b00000, 5'b00000);
        end
      endcase
      for (int k = 1; k <= n; k++) begin
        tick();
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL irq_sb edge=%0d got empty queue, need an entry", e);
        end else begin
          ex = sb.pop_front();
          if (ex.e !== e || {O_button, O_press, O_release} !== {ex.btn, ex.prs, ex.rel}) begin
            errors++;
            $display("FAIL irq_lvl ph=%0d edge=%0d got btn=%b prs=%b rel=%b, need btn=%b prs=%b rel=%b",
                     phase, e, O_button, O_press, O_release, ex.btn, ex.prs, ex.rel);
          end
          m_press_prev = ex.prs;
        end
        checks++;
        if ({O_pending, O_irq} !== {m_pend, |m_pend}) begin
          errors++; $display("FAIL irq ph=%0d k=%0d got pend=%b irq=%b, need pend=%b irq=%b",
                             phase, k, O_pending, O_irq, m_pend, |m_pend);
        end
        if (phase == 0) rst = 1'b0;
        if (phase == 3 && k == 10) clr = 5'b01000;
        if (phase == 3 && k == 11) clr = 5'b00000;
        if (phase == 4 && k == 1)  clr = 5'b00000;
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_release_simul();
    test_reset_mid();
    test_irq();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain got %0d leftover entries, need 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got no finish by time %0t, need finish earlier", $time);
    $fatal(1);
  end

endmodule
